// File: rtl/ysyx_23060236_wbu_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060236_wbu_if
// Bundle of the write-back stage signals shared by the decoder, the LSU and
// the write-back unit.
//   master : decoder/LSU side (drives issue, retire and kill requests)
//   slave  : write-back unit (drives read data, stall, ready, counters)
// Signals:
//   issue_valid/issue_wen/issue_rd   dispatch request and its destination
//   issue_rs1/issue_rs2              decode-stage source registers
//   rs1_val/rs2_val                  register file read data
//   raw_stall/issue_ready            hazard and dispatch-accept indications
//   wb_valid/wb_wen/wb_rd/wb_val     one-cycle retire pulse from the LSU
//   kill_valid/kill_rd               reservation release for squashed ops
//   retire_cnt/sb_err                retired count and sticky underflow flag
// ----------------------------------------------------------------------------
interface ysyx_23060236_wbu_if #(
    parameter int AW = 4
);
    logic          issue_valid;
    logic          issue_wen;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] issue_rs1;
    logic [AW-1:0] issue_rs2;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;
    logic          raw_stall;
    logic          issue_ready;
    logic          wb_valid;
    logic [31:0]   wb_val;
    logic [AW-1:0] wb_rd;
    logic          wb_wen;
    logic          kill_valid;
    logic [AW-1:0] kill_rd;
    logic [31:0]   retire_cnt;
    logic          sb_err;

    modport master (
        output issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
        output wb_valid, wb_val, wb_rd, wb_wen, kill_valid, kill_rd,
        input  rs1_val, rs2_val, raw_stall, issue_ready, retire_cnt, sb_err
    );

    modport slave (
        input  issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
        input  wb_valid, wb_val, wb_rd, wb_wen, kill_valid, kill_rd,
        output rs1_val, rs2_val, raw_stall, issue_ready, retire_cnt, sb_err
    );
endinterface

// File: rtl/ysyx_23060236_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_23060236_wbu
// Write-back stage: owns the GPR file (x0 hard-wired to zero), keeps a
// per-register pending-write counter used for RAW hazard detection and
// issue throttling, and counts retired instructions.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ysyx_23060236_wbu_if.slave (issue, retire, kill, read data,
//           raw_stall, issue_ready, retire_cnt, sb_err)
// Optional feature:
//   YSYX_23060236_WB_BYPASS_EN : forward the retiring value to the read ports
//   in the retire cycle; a source whose last pending write is retiring then
//   does not stall.
// ----------------------------------------------------------------------------
module ysyx_23060236_wbu #(
    parameter int NR_REG = 16,
    parameter int AW     = 4,
    parameter int CNT_W  = 2
) (
    input logic                  clock,
    input logic                  reset,
    ysyx_23060236_wbu_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    REG_X0   = {AW{1'b0}};

    logic [31:0]      r_gpr [NR_REG];
    logic [CNT_W-1:0] r_cnt [NR_REG];
    logic [31:0]      r_retire_cnt;
    logic             r_sb_err;

    logic             w_wb_wr;
    logic             w_kill;
    logic             w_reserve;
    logic             w_stall1;
    logic             w_stall2;
    logic             w_raw_stall;
    logic             w_issue_ready;
    logic [31:0]      w_rs1_val;
    logic [31:0]      w_rs2_val;
    logic [CNT_W:0]   w_cnt_res [NR_REG];
    logic             w_uflow;

    // New counter value from current count, one increment and two decrements.
    // Top bit of the result flags an underflow, in which case the count is 0.
    function automatic logic [CNT_W:0] cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec_a,
        input logic             dec_b
    );
        logic [CNT_W+1:0] up;
        logic [CNT_W+1:0] dn;
        logic [CNT_W+1:0] diff;
        up = (CNT_W+2)'(cnt) + (CNT_W+2)'(inc);
        dn = (CNT_W+2)'(dec_a) + (CNT_W+2)'(dec_b);
        if (up < dn) begin
            cnt_next = {1'b1, CNT_ZERO};
        end else begin
            diff     = up - dn;
            cnt_next = {1'b0, diff[CNT_W-1:0]};
        end
    endfunction

    assign w_wb_wr   = bus.wb_valid & bus.wb_wen & (bus.wb_rd != REG_X0);
    assign w_kill    = bus.kill_valid & (bus.kill_rd != REG_X0);
    assign w_reserve = bus.issue_valid & w_issue_ready & bus.issue_wen
                     & (bus.issue_rd != REG_X0);

    // Read ports and per-source hazard evaluation.
    always_comb begin
        logic busy1;
        logic busy2;
        busy1     = (bus.issue_rs1 != REG_X0) & (r_cnt[bus.issue_rs1] != CNT_ZERO);
        busy2     = (bus.issue_rs2 != REG_X0) & (r_cnt[bus.issue_rs2] != CNT_ZERO);
        w_rs1_val = (bus.issue_rs1 == REG_X0) ? 32'd0 : r_gpr[bus.issue_rs1];
        w_rs2_val = (bus.issue_rs2 == REG_X0) ? 32'd0 : r_gpr[bus.issue_rs2];
        w_stall1  = busy1;
        w_stall2  = busy2;
`ifdef YSYX_23060236_WB_BYPASS_EN
        // w_wb_wr already excludes x0, so a hit implies a non-zero source.
        if (w_wb_wr && (bus.wb_rd == bus.issue_rs1)) begin
            w_rs1_val = bus.wb_val;
            w_stall1  = busy1 & (r_cnt[bus.issue_rs1] != CNT_ONE);
        end else begin
            w_stall1  = busy1;
        end
        if (w_wb_wr && (bus.wb_rd == bus.issue_rs2)) begin
            w_rs2_val = bus.wb_val;
            w_stall2  = busy2 & (r_cnt[bus.issue_rs2] != CNT_ONE);
        end else begin
            w_stall2  = busy2;
        end
`else
        w_stall1  = busy1;
        w_stall2  = busy2;
`endif
    end

    // Dispatch gating: stall on hazard, or block a reservation on a saturated counter.
    always_comb begin
        w_raw_stall   = w_stall1 | w_stall2;
        w_issue_ready = ~w_raw_stall
                      & ~(bus.issue_wen & (bus.issue_rd != REG_X0)
                          & (r_cnt[bus.issue_rd] == CNT_MAX));
    end

    // Net per-register counter update from reserve, retire and kill.
    always_comb begin
        w_uflow = 1'b0;
        for (int r = 0; r < NR_REG; r++) begin
            w_cnt_res[r] = cnt_next(r_cnt[r],
                                    w_reserve & (bus.issue_rd == AW'(r)),
                                    w_wb_wr   & (bus.wb_rd    == AW'(r)),
                                    w_kill    & (bus.kill_rd  == AW'(r)));
            w_uflow      = w_uflow | w_cnt_res[r][CNT_W];
        end
    end

    // Register file, scoreboard counters, retire counter and sticky error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NR_REG; r++) begin
                r_gpr[r] <= 32'd0;
                r_cnt[r] <= CNT_ZERO;
            end
            r_retire_cnt <= 32'd0;
            r_sb_err     <= 1'b0;
        end else begin
            if (w_wb_wr) begin
                r_gpr[bus.wb_rd] <= bus.wb_val;
            end
            for (int r = 0; r < NR_REG; r++) begin
                r_cnt[r] <= w_cnt_res[r][CNT_W-1:0];
            end
            if (bus.wb_valid) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
            r_sb_err <= r_sb_err | w_uflow;
        end
    end

    assign bus.rs1_val     = w_rs1_val;
    assign bus.rs2_val     = w_rs2_val;
    assign bus.raw_stall   = w_raw_stall;
    assign bus.issue_ready = w_issue_ready;
    assign bus.retire_cnt  = r_retire_cnt;
    assign bus.sb_err      = r_sb_err;

endmodule

// File: tb/tb_ysyx_23060236_wbu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060236_wbu
// Self-checking bench for the write-back stage: reset state, write/readback,
// RAW stall (with or without YSYX_23060236_WB_BYPASS_EN), counter saturation,
// kill/underflow, x0 handling and reset in mid-operation.
// ----------------------------------------------------------------------------
module tb_ysyx_23060236_wbu;

    localparam int AW = 4;

    typedef struct {
        logic [AW-1:0] rd;
        logic [31:0]   val;
        logic [31:0]   exp;
    } vec_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [31:0]   exp;
    } sb_t;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_retire = 32'd0;
    vec_t vecs [7];
    sb_t  q [$];

    ysyx_23060236_wbu_if #(.AW(AW)) bus ();

    ysyx_23060236_wbu #(.NR_REG(16), .AW(AW), .CNT_W(2)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Bound the whole run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_wen   = 1'b0;
        bus.issue_rd    = 4'd0;
        bus.issue_rs1   = 4'd0;
        bus.issue_rs2   = 4'd0;
        bus.wb_valid    = 1'b0;
        bus.wb_val      = 32'd0;
        bus.wb_rd       = 4'd0;
        bus.wb_wen      = 1'b0;
        bus.kill_valid  = 1'b0;
        bus.kill_rd     = 4'd0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_wen   = 1'b1;
        bus.issue_rd    = rd;
    endtask

    task automatic wb(input logic [AW-1:0] rd, input logic [31:0] val);
        bus.wb_valid = 1'b1;
        bus.wb_wen   = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_val   = val;
        exp_retire   = exp_retire + 32'd1;
    endtask

    task automatic kill(input logic [AW-1:0] rd);
        bus.kill_valid = 1'b1;
        bus.kill_rd    = rd;
    endtask

    // Stimulus and checks.
    initial begin
        sb_t e;
        vecs[0] = '{rd: 4'd1,  val: 32'h0000_0001, exp: 32'h0000_0001};
        vecs[1] = '{rd: 4'd2,  val: 32'hA5A5_A5A5, exp: 32'hA5A5_A5A5};
        vecs[2] = '{rd: 4'd5,  val: 32'h5A5A_5A5A, exp: 32'h5A5A_5A5A};
        vecs[3] = '{rd: 4'd9,  val: 32'h9999_0009, exp: 32'h9999_0009};
        vecs[4] = '{rd: 4'd15, val: 32'hFFFF_0000, exp: 32'hFFFF_0000};
        vecs[5] = '{rd: 4'd0,  val: 32'h1234_5678, exp: 32'h0000_0000};
        vecs[6] = '{rd: 4'd12, val: 32'h8000_0000, exp: 32'h8000_0000};

        // Reset state
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        bus.issue_rs1 = 4'd5;
        settle();
        chk("rst_rs1_val", bus.rs1_val, 32'd0);
        chk("rst_retire", bus.retire_cnt, 32'd0);
        chk("rst_ready", {31'd0, bus.issue_ready}, 32'd1);
        chk("rst_sb_err", {31'd0, bus.sb_err}, 32'd0);
        chk("rst_raw", {31'd0, bus.raw_stall}, 32'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_rs1_val", bus.rs1_val, 32'd0);
        chk("post_rst_ready", {31'd0, bus.issue_ready}, 32'd1);

        // Basic write to x3
        idle(); issue(4'd3); settle();
        chk("ready_x3", {31'd0, bus.issue_ready}, 32'd1);
        tick();
        idle(); bus.issue_rs1 = 4'd3; settle();
        chk("busy_x3", {31'd0, bus.raw_stall}, 32'd1);
        wb(4'd3, 32'hDEAD_BEEF); settle();
`ifdef YSYX_23060236_WB_BYPASS_EN
        chk("byp_x3_val", bus.rs1_val, 32'hDEAD_BEEF);
        chk("byp_x3_raw", {31'd0, bus.raw_stall}, 32'd0);
`else
        chk("nobyp_x3_raw", {31'd0, bus.raw_stall}, 32'd1);
`endif
        tick();
        idle(); bus.issue_rs1 = 4'd3; settle();
        chk("x3_val", bus.rs1_val, 32'hDEAD_BEEF);
        chk("x3_raw", {31'd0, bus.raw_stall}, 32'd0);
        chk("retire_1", bus.retire_cnt, exp_retire);

        // RAW stall on x7 through rs2
        idle(); issue(4'd7); tick();
        idle(); bus.issue_rs2 = 4'd7; settle();
        chk("raw_x7_a", {31'd0, bus.raw_stall}, 32'd1);
        chk("ready_x7_a", {31'd0, bus.issue_ready}, 32'd0);
        tick();
        chk("raw_x7_b", {31'd0, bus.raw_stall}, 32'd1);
        wb(4'd7, 32'h0000_0012); settle();
`ifdef YSYX_23060236_WB_BYPASS_EN
        chk("byp_x7_val", bus.rs2_val, 32'h0000_0012);
        chk("byp_x7_raw", {31'd0, bus.raw_stall}, 32'd0);
`else
        chk("nobyp_x7_raw", {31'd0, bus.raw_stall}, 32'd1);
        chk("nobyp_x7_val", bus.rs2_val, 32'd0);
`endif
        tick();
        idle(); bus.issue_rs2 = 4'd7; settle();
        chk("raw_x7_after", {31'd0, bus.raw_stall}, 32'd0);
        chk("x7_val", bus.rs2_val, 32'h0000_0012);

        // Saturation of cnt[4]
        for (int i = 0; i < 3; i++) begin
            idle(); issue(4'd4); settle();
            chk("ready_x4_fill", {31'd0, bus.issue_ready}, 32'd1);
            tick();
        end
        idle(); issue(4'd4); settle();
        chk("ready_x4_sat", {31'd0, bus.issue_ready}, 32'd0);
        tick();
        idle(); wb(4'd4, 32'h0000_0044); tick();
        idle(); issue(4'd4); settle();
        chk("ready_x4_after_ret", {31'd0, bus.issue_ready}, 32'd1);
        // Same-cycle issue and retire: net zero
        wb(4'd4, 32'h0000_0045); settle();
        chk("ready_x4_simul", {31'd0, bus.issue_ready}, 32'd1);
        tick();
        idle(); issue(4'd4); settle();
        chk("ready_x4_cnt2", {31'd0, bus.issue_ready}, 32'd1);
        tick();
        idle(); issue(4'd4); settle();
        chk("ready_x4_cnt3", {31'd0, bus.issue_ready}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); wb(4'd4, 32'h0000_0040 + 32'(i)); tick();
        end
        idle(); bus.issue_rs1 = 4'd4; settle();
        chk("x4_drained", {31'd0, bus.raw_stall}, 32'd0);
        chk("x4_val", bus.rs1_val, 32'h0000_0042);
        chk("x4_sb_err", {31'd0, bus.sb_err}, 32'd0);
        chk("retire_x4", bus.retire_cnt, exp_retire);

        // Table of writes, expected values queued at retire and checked on readback
        for (int i = 0; i < 7; i++) begin
            idle(); issue(vecs[i].rd); settle();
            chk("ready_vec", {31'd0, bus.issue_ready}, 32'd1);
            tick();
            idle(); wb(vecs[i].rd, vecs[i].val);
            q.push_back('{rd: vecs[i].rd, exp: vecs[i].exp});
            tick();
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            idle(); bus.issue_rs1 = e.rd; bus.issue_rs2 = e.rd; settle();
            chk("vec_rs1", bus.rs1_val, e.exp);
            chk("vec_rs2", bus.rs2_val, e.exp);
            chk("vec_raw", {31'd0, bus.raw_stall}, 32'd0);
            tick();
        end
        chk("retire_vec", bus.retire_cnt, exp_retire);

        // Kill releases x9 without touching the GPR; second kill underflows
        idle(); issue(4'd9); tick();
        idle(); bus.issue_rs1 = 4'd9; settle();
        chk("busy_x9", {31'd0, bus.raw_stall}, 32'd1);
        kill(4'd9); tick();
        idle(); bus.issue_rs1 = 4'd9; settle();
        chk("kill_x9_raw", {31'd0, bus.raw_stall}, 32'd0);
        chk("kill_x9_val", bus.rs1_val, 32'h9999_0009);
        chk("kill_sb_err0", {31'd0, bus.sb_err}, 32'd0);
        kill(4'd9); tick();
        idle(); settle();
        chk("uflow_sb_err", {31'd0, bus.sb_err}, 32'd1);
        repeat (2) tick();
        chk("sticky_sb_err", {31'd0, bus.sb_err}, 32'd1);

        // x0 handling
        idle(); wb(4'd0, 32'hFFFF_FFFF); tick();
        idle(); issue(4'd0); settle();
        chk("x0_ready", {31'd0, bus.issue_ready}, 32'd1);
        tick();
        idle(); bus.issue_rs1 = 4'd0; bus.issue_rs2 = 4'd0; settle();
        chk("x0_val", bus.rs1_val, 32'd0);
        chk("x0_raw", {31'd0, bus.raw_stall}, 32'd0);
        chk("x0_retire", bus.retire_cnt, exp_retire);

        // Reset in mid-operation: reservation and same-cycle retire are lost
        idle(); issue(4'd11); tick();
        idle(); wb(4'd11, 32'h0000_0BAD); reset = 1'b0; settle();
        chk("midrst_retire", bus.retire_cnt, 32'd0);
        chk("midrst_sb_err", {31'd0, bus.sb_err}, 32'd0);
        tick();
        idle(); reset = 1'b1; exp_retire = 32'd0; tick();
        bus.issue_rs1 = 4'd11; bus.issue_rs2 = 4'd3; settle();
        chk("midrst_x11_raw", {31'd0, bus.raw_stall}, 32'd0);
        chk("midrst_x11_val", bus.rs1_val, 32'd0);
        chk("midrst_x3_val", bus.rs2_val, 32'd0);
        chk("midrst_retire2", bus.retire_cnt, exp_retire);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060236_wbu.md
# ysyx_23060236_wbu

Write-back stage of the ysyx_23060236 core, directly downstream of the load/store unit. It accepts the single-cycle `wb_valid` pulse and 32-bit result from the LSU and writes it into the general-purpose register file, which this block owns. It tracks in-flight destination registers with a per-register pending-write scoreboard, giving the decoder read data, a RAW stall and an issue-accept signal. It also maintains a retired-instruction counter.

## Interface
Parameters:
- `NR_REG`, 16: number of GPRs (RV32E); x0 is hard-wired to zero.
- `AW`, 4: register index width, equal to log2(`NR_REG`).
- `CNT_W`, 2: width of each scoreboard pending counter.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decoder is dispatching an instruction this cycle.
- `issue_wen`  in  1  the dispatched instruction writes `issue_rd`.
- `issue_rd`  in  AW  destination register of the dispatched instruction.
- `issue_rs1`, `issue_rs2`  in  AW each  source registers of the instruction at decode.
- `rs1_val`, `rs2_val`  out  32 each  register file read data.
- `raw_stall`  out  1  a source register has a pending write that is not bypassable.
- `issue_ready`  out  1  the decoder may dispatch this cycle.
- `wb_valid`  in  1  one-cycle pulse from the LSU; there is no backpressure.
- `wb_val`  in  32  result to write.
- `wb_rd`  in  AW  destination register of the retiring instruction.
- `wb_wen`  in  1  the retiring instruction writes a register.
- `kill_valid`  in  1  a squashed instruction (mispredicted path) releases its reservation.
- `kill_rd`  in  AW  register reserved by the squashed instruction.
- `retire_cnt`  out  32  number of `wb_valid` pulses since reset; wraps modulo 2^32.
- `sb_err`  out  1  sticky flag: a release or retire was seen against a counter already at 0.

## Operation
- **Write.** On `wb_valid & wb_wen & (wb_rd != 0)`, `gpr[wb_rd] <= wb_val`. Writes to x0 are dropped.
- **Read.** Reads are combinational. `rsN_val` is 0 when `rsN == 0`.
- **Reserve.** On `issue_valid & issue_ready & issue_wen & (issue_rd != 0)`, `cnt[issue_rd]` increments by 1.
- **Release on retire.** On `wb_valid & wb_wen & (wb_rd != 0)`, `cnt[wb_rd]` decrements by 1.
- **Release on kill.** On `kill_valid & (kill_rd != 0)`, `cnt[kill_rd]` decrements by 1. No GPR write occurs.
- **Net update.** The increment and the decrements are summed per register each cycle. Issue, retire and kill on the same register in the same cycle gives a net change of -1.
- **Underflow.** A decrement that would take a counter below 0 leaves the counter at 0 and sets `sb_err`. `sb_err` clears only on reset.
- **Busy.** `busy(r) = cnt[r] != 0`. Register x0 is never busy.
- **`raw_stall`** = (`busy(rs1)` and not bypassable) or (`busy(rs2)` and not bypassable). Bypassability is defined under Configuration.
- **`issue_ready`** = `~raw_stall & ~(issue_wen & (cnt[issue_rd] == 2^CNT_W - 1) & (issue_rd != 0))`. A saturated counter blocks issue rather than wrapping.
- **Retire count.** `retire_cnt` increments on every `wb_valid`, regardless of `wb_wen`.

## Timing
- **Reset.** Asserting `reset` low clears at once all GPRs, all `cnt[]`, `retire_cnt` and `sb_err`. The combinational outputs then read `rs*_val` = 0, `raw_stall` = 0 and `issue_ready` = 1.
- **Reset mid-operation.** In-flight reservations are discarded. A `wb_valid` arriving in the same cycle as `reset` low is lost.
- **Write visibility.** A write made at edge N is visible on the read ports in cycle N+1 in all builds.
- **Scoreboard visibility.** Counter updates are visible at the edge after the event. An issue in cycle N makes `rd` busy from cycle N+1.
- **Combinational outputs.** `raw_stall` and `issue_ready` have no registered latency; they depend on the current-cycle inputs.
- **Back-to-back retires.** Consecutive `wb_valid` pulses, one per cycle, are all accepted.

## Configuration
- **`YSYX_23060236_WB_BYPASS_EN` defined:**
  - When `wb_valid & wb_wen & (wb_rd == rsN) & (rsN != 0)`, `rsN_val = wb_val` in the same cycle.
  - That source counts as bypassable if `cnt[rsN] == 1`, i.e. this retire is its last pending write. It then does not raise `raw_stall`.
- **Macro undefined:**
  - No forwarding path.
  - `raw_stall` is asserted whenever `busy(rsN)` is true for either source, including in the retire cycle.
  - The dependent instruction issues one cycle later.

## Test plan
- **Reset state.** Drive `reset` low, then release it; read x5 -> `rs1_val` = 0, `retire_cnt` = 0, `issue_ready` = 1, `sb_err` = 0.
- **Basic write.**
  - Issue `rd`=3, then pulse `wb_valid` with `wb_rd`=3, `wb_val`=0xDEADBEEF.
  - Next cycle, `rs1`=3 -> `rs1_val` = 0xDEADBEEF, `raw_stall` = 0, `retire_cnt` = 1.
- **RAW stall and bypass.**
  - Issue `rd`=7, then hold `rs2`=7; `raw_stall` = 1 until retire.
  - In the retire cycle with `wb_val`=0x12: with BYPASS_EN, `rs2_val` = 0x12 and `raw_stall` = 0; without it, `raw_stall` = 1 that cycle and 0 the next.
- **Multiple reservations.**
  - Issue `rd`=4 three times -> `issue_ready` = 0 on a 4th issue to x4 (`CNT_W`=2).
  - Retire x4 once -> `issue_ready` returns to 1.
  - A simultaneous issue and retire to x4 leaves `cnt[4]` unchanged.
- **Kill and underflow.**
  - Issue `rd`=9, then `kill_rd`=9 -> x9 is not busy and the GPR is unchanged.
  - A second kill of x9 -> `sb_err` = 1 and stays 1.
- **x0 handling.** Retire with `wb_rd`=0, `wb_val`=0xFFFFFFFF -> x0 reads 0, is never busy, and `retire_cnt` still increments.
